// File: rtl/decode_ctl.sv
// decode_ctl -- LZS token decoder control FSM.
// Consumes a 13-bit look-ahead window from a bit unpacker and emits one
// literal or match token per strobe. Stream acknowledges are combinational;
// token, done and error outputs are registered.
// Optional feature: define DECODE_CTL_ERR_EN to add an output-byte counter
// and the sticky err flag; without it err is tied low.
module decode_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] stream_data,
  input  logic        stream_valid,
  output logic [3:0]  stream_width,
  output logic        stream_ack,
  input  logic        fo_full,
  output logic        tok_valid,
  output logic        tok_match,
  output logic [7:0]  tok_lit,
  output logic [10:0] tok_off,
  output logic [11:0] tok_len,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_LEN,
    S_LEN_EXT,
    S_PAD,
    S_DONE
  } state_t;

  localparam logic [12:0] LEN_MAX = 13'd4095;

  state_t      state;
  logic [2:0]  bitcnt;     // stream position modulo one byte
  logic [11:0] acc;        // extended-length accumulator
  logic [10:0] off_q;      // offset held until its length is decoded

  logic        emit_lit;
  logic        emit_match;
  logic [12:0] len_sum;    // one spare bit to detect overflow past 4095
  logic [11:0] len_val;
  logic        len_ovf;
  logic [12:0] acc_inc;
  logic [11:0] acc_sat;
  logic [3:0]  nib;

  assign nib     = stream_data[12:9];
  assign acc_inc = {1'b0, acc} + 13'd15;
  assign acc_sat = acc_inc[12] ? LEN_MAX[11:0] : acc_inc[11:0];
  assign len_ovf = len_sum[12];
  assign len_val = len_ovf ? LEN_MAX[11:0] : len_sum[11:0];
  assign busy    = (state != S_IDLE);

  // Decode the current window: how many bits to consume and whether a token is emitted.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    stream_ack   = 1'b0;
    stream_width = 4'd0;
    emit_lit     = 1'b0;
    emit_match   = 1'b0;
    len_sum      = 13'd0;
    case (state)
      S_TOKEN: begin
        if (stream_valid) begin
          stream_width = 4'd9;
          if (!stream_data[12]) begin
            // Literal: the sink must have room for the token.
            stream_ack = !fo_full;
            emit_lit   = !fo_full;
          end else if (stream_data[11]) begin
            // Short offset or end marker, both 9 bits, never gated.
            stream_ack = 1'b1;
          end else begin
            // Long offset: 2-bit prefix plus 11-bit offset.
            stream_width = 4'd13;
            stream_ack   = 1'b1;
          end
        end
      end
      S_LEN: begin
        if (stream_valid) begin
          if (stream_data[12:11] != 2'b11) begin
            stream_width = 4'd2;
            len_sum      = 13'd2 + {11'd0, stream_data[12:11]};
            stream_ack   = !fo_full;
            emit_match   = !fo_full;
          end else if (stream_data[10:9] != 2'b11) begin
            stream_width = 4'd4;
            len_sum      = 13'd5 + {11'd0, stream_data[10:9]};
            stream_ack   = !fo_full;
            emit_match   = !fo_full;
          end else begin
            // 1111: start of an extended length, nothing emitted yet.
            stream_width = 4'd4;
            stream_ack   = 1'b1;
          end
        end
      end
      S_LEN_EXT: begin
        if (stream_valid) begin
          stream_width = 4'd4;
          if (nib == 4'hF) begin
            stream_ack = 1'b1;
          end else begin
            len_sum    = {1'b0, acc} + {9'd0, nib};
            stream_ack = !fo_full;
            emit_match = !fo_full;
          end
        end
      end
      S_PAD: begin
        // Skip to the next byte boundary; nothing to skip when already aligned.
        if (stream_valid && bitcnt != 3'd0) begin
          stream_width = 4'd8 - {1'b0, bitcnt};
          stream_ack   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Main FSM with registered token, done and position state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bitcnt    <= 3'd0;
      acc       <= 12'd0;
      off_q     <= 11'd0;
      tok_valid <= 1'b0;
      tok_match <= 1'b0;
      tok_lit   <= 8'd0;
      tok_off   <= 11'd0;
      tok_len   <= 12'd0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      tok_valid <= 1'b0;
      done      <= 1'b0;

      // Widths are at most 13, so adding the low three bits is exact modulo 8.
      if (stream_ack) bitcnt <= bitcnt + stream_width[2:0];

      if (emit_lit) begin
        tok_valid <= 1'b1;
        tok_match <= 1'b0;
        tok_lit   <= stream_data[11:4];
      end
      if (emit_match) begin
        tok_valid <= 1'b1;
        tok_match <= 1'b1;
        tok_off   <= off_q;
        tok_len   <= len_val;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_TOKEN;
            bitcnt <= 3'd0;
            acc    <= 12'd0;
          end
        end
        S_TOKEN: begin
          if (stream_ack && stream_data[12]) begin
            if (stream_data[11]) begin
              if (stream_data[10:4] == 7'd0) begin
                state <= S_PAD;
              end else begin
                off_q <= {4'b0, stream_data[10:4]};
                state <= S_LEN;
              end
            end else begin
              off_q <= stream_data[10:0];
              state <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (stream_ack) begin
            if (stream_data[12:9] == 4'hF) begin
              acc   <= 12'd8;
              state <= S_LEN_EXT;
            end else begin
              state <= S_TOKEN;
            end
          end
        end
        S_LEN_EXT: begin
          if (stream_ack) begin
            if (nib == 4'hF) acc <= acc_sat;
            else             state <= S_TOKEN;
          end
        end
        S_PAD: begin
          if (bitcnt == 3'd0 || stream_ack) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DECODE_CTL_ERR_EN
  logic [10:0] byte_cnt;   // bytes produced so far, saturating at 2047
  logic        len_sat;    // extended length clamped during this match
  logic [12:0] byte_sum;

  assign byte_sum = {2'b0, byte_cnt} + (emit_match ? {1'b0, len_val} : 13'd1);

  // Track produced bytes and raise the sticky error on bad offsets or clamped lengths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 11'd0;
      len_sat  <= 1'b0;
      err      <= 1'b0;
    end else if (state == S_IDLE && start) begin
      byte_cnt <= 11'd0;
      len_sat  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == S_LEN && stream_ack) len_sat <= 1'b0;
      if (state == S_LEN_EXT && stream_ack && nib == 4'hF && acc_inc[12]) len_sat <= 1'b1;
      if (emit_lit || emit_match)
        byte_cnt <= (byte_sum > 13'd2047) ? 11'd2047 : byte_sum[10:0];
      if (emit_match && (off_q == 11'd0 || off_q > byte_cnt || len_sat || len_ovf))
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/decode_ctl.md
DECODE_CTL -- requirements
Module: decode_ctl

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL provide the following ports:
- start  input  1  pulse; begin decoding one LZS stream.
- stream_data  input  13  bit window from unpacker; [12] = next bit.
- stream_valid  input  1  window holds at least 13 valid bits.
- stream_width  output  4  bits consumed on this ack (1..13).
- stream_ack  output  1  consume stream_width bits this cycle.
- fo_full  input  1  token sink cannot accept.
- tok_valid  output  1  one-cycle token strobe.
- tok_match  output  1  1 = match token, 0 = literal.
- tok_lit  output  8  literal byte.
- tok_off  output  11  match offset.
- tok_len  output  12  match length.
- busy  output  1  decoding in progress.
- done  output  1  one-cycle pulse after end marker and pad are consumed.
- err  output  1  sticky error flag (see REQ-020).

Function
REQ-003 stream_ack SHALL be combinational and asserted only when stream_valid=1 and the current state requires consumption; stream_width SHALL be valid whenever stream_ack=1.
REQ-004 States SHALL be IDLE, TOKEN, LEN, LEN_EXT, PAD and DONE; busy=1 in every state except IDLE.
REQ-005 IDLE: start=1 -> TOKEN, clear bitcnt and length accumulator; start is ignored in other states.
REQ-006 TOKEN, stream_data[12]=0 (literal): ack only if ~fo_full; width 9; next cycle tok_valid=1, tok_match=0, tok_lit=stream_data[11:4]; remain TOKEN.
REQ-007 TOKEN, [12:11]=11, [10:4]=0 (end marker): width 9, no token emitted -> PAD.
REQ-008 TOKEN, [12:11]=11, [10:4]!=0: width 9, latch tok_off={4'b0,[10:4]} -> LEN.
REQ-009 TOKEN, [12:11]=10: width 13, latch tok_off=[10:0] -> LEN.
REQ-010 LEN: [12:11]=00/01/10 -> width 2, length 2/3/4; [12:9]=1100/1101/1110 -> width 4, length 5/6/7; emission (and ack) gated by ~fo_full -> TOKEN. [12:9]=1111 -> width 4, accumulator=8, no emission, ack not gated -> LEN_EXT.
REQ-011 LEN_EXT: nibble=[12:9]; 1111 -> width 4, accumulator+=15, stay; otherwise -> gated by ~fo_full, width 4, length=accumulator+nibble, emit -> TOKEN.
REQ-012 Match emission: tok_valid=1 one cycle after the ack, tok_match=1, tok_off latched value, tok_len=length; tok_* SHALL hold until the next emission.
REQ-013 Accumulator and tok_len SHALL saturate at 4095, never wrap.
REQ-014 bitcnt (3-bit) SHALL add stream_width modulo 8 on every ack.
REQ-015 PAD: if bitcnt=0, go to DONE with no ack; else ack width 8-bitcnt (pad bits not checked) -> DONE.
REQ-016 DONE: done=1 for exactly one cycle -> IDLE.
REQ-017 stream_valid=0 in any consuming state SHALL stall the FSM with no ack and no state change; fo_full=1 SHALL stall only emitting acks.
REQ-018 At most one ack and at most one tok_valid SHALL occur per cycle.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, bitcnt=0, accumulator=0, tok_valid=0, tok_match=0, tok_lit=0, tok_off=0, tok_len=0, done=0, err=0, with stream_ack=0 while reset is asserted; reset mid-stream discards all partial token state.

Configuration
REQ-020 Macro DECODE_CTL_ERR_EN: when defined, an 11-bit output-byte counter (saturating at 2047, cleared on start) SHALL track emitted bytes; err SHALL set on a match whose offset is 0 or exceeds the counter, or on length saturation; err SHALL clear only on start or reset, and the token is still emitted. When not defined, err SHALL be tied 0 and no counter SHALL exist.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Literal: start, window bits 0_01000001 -> ack width 9, next cycle tok_valid, tok_lit=0x41.
- Short match: 11_0000011_01 -> acks width 9 then 2, tok_off=3, tok_len=3.
- Long match: 10_00000010000_1111_1111_0010 -> acks width 13,4,4,4, tok_off=16, tok_len=8+15+2=25.
- End/pad: 9 literal bits then end marker (bitcnt=2) -> pad ack width 6, then done pulse and busy=0.
- Backpressure: fo_full=1 with literal pending -> no ack for 5 cycles; release -> one ack, one tok_valid.
- With DECODE_CTL_ERR_EN: first token a match with offset 5 -> err=1, cleared by next start.
